// File: rtl/area_sequencer_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | area_sequencer_pkg                                                       |
// | Shared FSM encoding and 8.8 fixed-point format constants.                |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
package area_sequencer_pkg;

    localparam int FRAC_W = 8;
    localparam int INT_W  = 8;
    localparam int FIX_W  = INT_W + FRAC_W;

    localparam logic [FIX_W-1:0] FRAC_ONE = 16'd256;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_ISSUE = 3'd1,
        S_WAIT  = 3'd2,
        S_OUT   = 3'd3,
        S_ADV   = 3'd4,
        S_DONE  = 3'd5
    } state_t;

endpackage
`default_nettype wire

// File: rtl/area_sequencer_coord_accum.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | coord_accum                                                              |
// | Raster x/y counters and 8.8 source-position accumulators.                |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module coord_accum
    import area_sequencer_pkg::*;
#(
    parameter int DIM_W = 11
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   load,
    input  logic                   advance,
    input  logic [DIM_W-1:0]       dst_w,
    input  logic [DIM_W-1:0]       dst_h,
    input  logic [FIX_W-1:0]       step_x,
    input  logic [FIX_W-1:0]       step_y,
    output logic [DIM_W+FIX_W-1:0] acc_x,
    output logic [DIM_W+FIX_W-1:0] acc_y,
    output logic [DIM_W+FIX_W-1:0] acc_x_nxt,
    output logic [DIM_W+FIX_W-1:0] acc_y_nxt,
    output logic                   last_pixel
);

    localparam int ACC_W = DIM_W + FIX_W;

    logic [DIM_W-1:0] x_cnt, y_cnt, x_nxt, y_nxt;
    logic [DIM_W-1:0] width, height;
    logic [FIX_W-1:0] stp_x, stp_y;

    assign last_pixel = (x_cnt == width - DIM_W'(1)) && (y_cnt == height - DIM_W'(1));

    always_comb begin
        x_nxt     = x_cnt;
        y_nxt     = y_cnt;
        acc_x_nxt = acc_x;
        acc_y_nxt = acc_y;
        if (load) begin
            x_nxt     = '0;
            y_nxt     = '0;
            acc_x_nxt = '0;
            acc_y_nxt = '0;
        end else if (advance) begin
            if (x_cnt < width - DIM_W'(1)) begin
                x_nxt     = x_cnt + DIM_W'(1);
                acc_x_nxt = acc_x + ACC_W'(stp_x);
            end else begin
                x_nxt     = '0;
                acc_x_nxt = '0;
                y_nxt     = y_cnt + DIM_W'(1);
                acc_y_nxt = acc_y + ACC_W'(stp_y);
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            x_cnt  <= '0;
            y_cnt  <= '0;
            acc_x  <= '0;
            acc_y  <= '0;
            width  <= '0;
            height <= '0;
            stp_x  <= '0;
            stp_y  <= '0;
        end else begin
            x_cnt <= x_nxt;
            y_cnt <= y_nxt;
            acc_x <= acc_x_nxt;
            acc_y <= acc_y_nxt;
            if (load) begin
                width  <= dst_w;
                height <= dst_h;
                stp_x  <= step_x;
                stp_y  <= step_y;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/area_sequencer.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | area_sequencer                                                           |
// | Walks a destination frame, requests areas and emits weight sets.         |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module area_sequencer
    import area_sequencer_pkg::*;
#(
    parameter int MIN_WAIT = 2,
    parameter int DIM_W    = 11
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [DIM_W-1:0] dst_w,
    input  logic [DIM_W-1:0] dst_h,
    input  logic [15:0]      step_x,
    input  logic [15:0]      step_y,
    output logic [15:0]      top,
    output logic [15:0]      bottom,
    output logic [15:0]      left,
    output logic [15:0]      right,
    output logic             area_req,
    input  logic             area_rdy,
    input  logic [15:0]      a_mn,
    input  logic [15:0]      a_m1n,
    input  logic [15:0]      a_m1n1,
    input  logic [15:0]      a_mn1,
    output logic [15:0]      w_mn,
    output logic [15:0]      w_m1n,
    output logic [15:0]      w_m1n1,
    output logic [15:0]      w_mn1,
    output logic [DIM_W-1:0] src_x,
    output logic [DIM_W-1:0] src_y,
    output logic             w_valid,
    input  logic             w_ready,
    output logic             busy,
    output logic             done
);

    localparam int ACC_W  = DIM_W + FIX_W;
    localparam int WCNT_W = $clog2(MIN_WAIT + 1) + 1;

    state_t            state, state_nxt;
    logic [WCNT_W-1:0] wait_cnt;
    logic              wait_done;
    logic              load, advance, capture, load_frac, last_pixel;
    logic [ACC_W-1:0]  acc_x, acc_y, acc_x_nxt, acc_y_nxt;
    logic [FRAC_W-1:0] fx, fy;
    logic              unused_bits;

    coord_accum #(.DIM_W(DIM_W)) u_coord (
        .clk        (clk),
        .reset      (reset),
        .load       (load),
        .advance    (advance),
        .dst_w      (dst_w),
        .dst_h      (dst_h),
        .step_x     (step_x),
        .step_y     (step_y),
        .acc_x      (acc_x),
        .acc_y      (acc_y),
        .acc_x_nxt  (acc_x_nxt),
        .acc_y_nxt  (acc_y_nxt),
        .last_pixel (last_pixel)
    );

    // Fractions are taken from the next-cycle accumulator so they are valid in ISSUE.
    assign fx          = acc_x_nxt[FRAC_W-1:0];
    assign fy          = acc_y_nxt[FRAC_W-1:0];
    assign wait_done   = (wait_cnt >= WCNT_W'(MIN_WAIT));
    assign unused_bits = ^{acc_x[ACC_W-1:DIM_W+8], acc_x[7:0], acc_y[ACC_W-1:DIM_W+8],
                           acc_y[7:0], acc_x_nxt[ACC_W-1:FRAC_W], acc_y_nxt[ACC_W-1:FRAC_W]};

    assign area_req = (state == S_ISSUE);
    assign w_valid  = (state == S_OUT);
    assign busy     = (state != S_IDLE);
    assign done     = (state == S_DONE);

    always_comb begin
        state_nxt = state;
        load      = 1'b0;
        advance   = 1'b0;
        capture   = 1'b0;
        load_frac = 1'b0;
        case (state)
            S_IDLE: begin
                if (start) begin
                    load = 1'b1;
                    if (dst_w == '0 || dst_h == '0) begin
                        state_nxt = S_DONE;
                    end else begin
                        state_nxt = S_ISSUE;
                        load_frac = 1'b1;
                    end
                end
            end
            S_ISSUE: state_nxt = S_WAIT;
            S_WAIT: begin
                if (wait_done && area_rdy) begin
                    capture   = 1'b1;
                    state_nxt = S_OUT;
                end
            end
            S_OUT: begin
                if (w_ready) state_nxt = S_ADV;
            end
            S_ADV: begin
                advance = 1'b1;
                if (last_pixel) begin
                    state_nxt = S_DONE;
                end else begin
                    state_nxt = S_ISSUE;
                    load_frac = 1'b1;
                end
            end
            S_DONE:  state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state    <= S_IDLE;
            wait_cnt <= '0;
            top      <= '0;
            bottom   <= '0;
            left     <= '0;
            right    <= '0;
            w_mn     <= '0;
            w_m1n    <= '0;
            w_m1n1   <= '0;
            w_mn1    <= '0;
            src_x    <= '0;
            src_y    <= '0;
        end else begin
            state <= state_nxt;
            if (state != S_WAIT) begin
                wait_cnt <= '0;
            end else if (!wait_done) begin
                wait_cnt <= wait_cnt + WCNT_W'(1);
            end
            if (load_frac) begin
                top    <= {8'h00, fy};
                bottom <= FRAC_ONE - {8'h00, fy};
                left   <= {8'h00, fx};
                right  <= FRAC_ONE - {8'h00, fx};
            end
            if (capture) begin
                w_mn   <= a_mn;
                w_m1n  <= a_m1n;
                w_m1n1 <= a_m1n1;
                w_mn1  <= a_mn1;
                src_x  <= acc_x[DIM_W+7:8];
                src_y  <= acc_y[DIM_W+7:8];
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_area_sequencer.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_area_sequencer                                                        |
// | Directed self-checking bench for area_sequencer.                         |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module tb_area_sequencer;

    localparam int DIM_W = 11;

    logic             clk = 1'b0;
    logic             reset;
    logic             start;
    logic [DIM_W-1:0] dst_w, dst_h;
    logic [15:0]      step_x, step_y;
    logic [15:0]      top, bottom, left, right;
    logic             area_req, area_rdy;
    logic [15:0]      a_mn, a_m1n, a_m1n1, a_mn1;
    logic [15:0]      w_mn, w_m1n, w_m1n1, w_mn1;
    logic [DIM_W-1:0] src_x, src_y;
    logic             w_valid, w_ready, busy, done;

    int checks = 0;
    int errors = 0;

    area_sequencer #(.MIN_WAIT(2), .DIM_W(DIM_W)) dut (
        .clk(clk), .reset(reset), .start(start), .dst_w(dst_w), .dst_h(dst_h),
        .step_x(step_x), .step_y(step_y), .top(top), .bottom(bottom), .left(left),
        .right(right), .area_req(area_req), .area_rdy(area_rdy), .a_mn(a_mn),
        .a_m1n(a_m1n), .a_m1n1(a_m1n1), .a_mn1(a_mn1), .w_mn(w_mn), .w_m1n(w_m1n),
        .w_m1n1(w_m1n1), .w_mn1(w_mn1), .src_x(src_x), .src_y(src_y),
        .w_valid(w_valid), .w_ready(w_ready), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic start_frame(input int w, input int h, input logic [15:0] sx,
                               input logic [15:0] sy);
        dst_w  = DIM_W'(w);
        dst_h  = DIM_W'(h);
        step_x = sx;
        step_y = sy;
        start  = 1'b1;
        @(negedge clk);
        start  = 1'b0;
        dst_w  = '0;
        dst_h  = '0;
        step_x = 16'hFFFF;
        step_y = 16'hFFFF;
        check("start_busy", busy, 1);
        if (w != 0 && h != 0) check("start_lat", area_req, 1);
    endtask

    // One pixel: request fractions, capture latency, weights, optional stall.
    task automatic pixel(input logic [15:0] et, input logic [15:0] el, input int ex,
                         input int ey, input logic [15:0] aval, input bit hold);
        int n = 0;
        while (!area_req && n < 30) begin @(negedge clk); n++; end
        check("req_seen", area_req, 1);
        check("top", top, et);
        check("bottom", bottom, 32'd256 - et);
        check("left", left, el);
        check("right", right, 32'd256 - el);
        a_mn = aval; a_m1n = aval + 16'd1; a_m1n1 = aval + 16'd2; a_mn1 = aval + 16'd3;
        if (hold) w_ready = 1'b0;
        n = 0;
        @(negedge clk); n++;
        check("req_one_cycle", area_req, 0);
        while (!w_valid && n < 30) begin @(negedge clk); n++; end
        check("capture_lat", n, 4);
        a_mn = 16'hDEAD; a_m1n = 16'hDEAD; a_m1n1 = 16'hDEAD; a_mn1 = 16'hDEAD;
        check("w_mn", w_mn, aval);
        check("w_m1n1", w_m1n1, aval + 16'd2);
        check("w_mn1", w_mn1, aval + 16'd3);
        check("src_x", src_x, ex);
        check("src_y", src_y, ey);
        if (hold) begin
            for (int i = 0; i < 5; i++) begin
                @(negedge clk);
                check("stall_valid", w_valid, 1);
                check("stall_w_m1n", w_m1n, aval + 16'd1);
                check("stall_src_x", src_x, ex);
                check("stall_req", area_req, 0);
            end
            w_ready = 1'b1;
        end
        @(negedge clk);
        check("accepted", w_valid, 0);
    endtask

    task automatic expect_done();
        int n = 0;
        while (!done && n < 20) begin @(negedge clk); n++; end
        check("done_pulse", done, 1);
        check("done_no_req", area_req, 0);
        @(negedge clk);
        check("done_one_cycle", done, 0);
        check("idle_busy", busy, 0);
    endtask

    initial begin
        reset = 1'b0; start = 1'b0; dst_w = '0; dst_h = '0; step_x = '0; step_y = '0;
        area_rdy = 1'b1; w_ready = 1'b1;
        a_mn = '0; a_m1n = '0; a_m1n1 = '0; a_mn1 = '0;
        repeat (3) @(negedge clk);
        check("rst_busy", busy, 0);
        check("rst_req", area_req, 0);
        check("rst_valid", w_valid, 0);
        check("rst_bottom", bottom, 0);
        check("rst_right", right, 0);
        reset = 1'b1;
        @(negedge clk);

        // 2x1 frame, step_x = 1.5
        start_frame(2, 1, 16'h0180, 16'h0100);
        pixel(16'h0000, 16'h0000, 0, 0, 16'h1000, 1'b0);
        pixel(16'h0000, 16'h0080, 1, 0, 16'h2000, 1'b0);
        expect_done();

        // 3x2 frame, unit steps, with a stall on the third pixel
        start_frame(3, 2, 16'h0100, 16'h0100);
        pixel(16'h0000, 16'h0000, 0, 0, 16'h3000, 1'b0);
        pixel(16'h0000, 16'h0000, 1, 0, 16'h3100, 1'b0);
        pixel(16'h0000, 16'h0000, 2, 0, 16'h3200, 1'b1);
        pixel(16'h0000, 16'h0000, 0, 1, 16'h3300, 1'b0);
        pixel(16'h0000, 16'h0000, 1, 1, 16'h3400, 1'b0);
        pixel(16'h0000, 16'h0000, 2, 1, 16'h3500, 1'b0);
        expect_done();

        // Zero height: straight to DONE without a request
        start_frame(5, 0, 16'h0100, 16'h0100);
        check("zero_done", done, 1);
        check("zero_req", area_req, 0);
        @(negedge clk);
        check("zero_done_end", done, 0);
        check("zero_idle", busy, 0);

        // Reset while waiting on the second pixel, y step 1.25
        start_frame(2, 2, 16'h0180, 16'h0140);
        pixel(16'h0000, 16'h0000, 0, 0, 16'h4000, 1'b0);
        begin
            int n = 0;
            while (!area_req && n < 30) begin @(negedge clk); n++; end
            check("rr_req", area_req, 1);
            check("rr_left", left, 16'h0080);
        end
        @(negedge clk);
        #2 reset = 1'b0;
        #1;
        check("rr_busy", busy, 0);
        check("rr_req0", area_req, 0);
        check("rr_valid", w_valid, 0);
        check("rr_done", done, 0);
        check("rr_left0", left, 0);
        check("rr_right0", right, 0);
        check("rr_w_mn", w_mn, 0);
        check("rr_src_x", src_x, 0);
        repeat (3) begin
            @(negedge clk);
            check("rr_no_done", done, 0);
        end
        reset = 1'b1;
        @(negedge clk);
        check("rr_idle", busy, 0);
        start_frame(2, 1, 16'h0180, 16'h0100);
        pixel(16'h0000, 16'h0000, 0, 0, 16'h5000, 1'b0);
        pixel(16'h0000, 16'h0080, 1, 0, 16'h5100, 1'b0);
        expect_done();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
